ls_queue: RTL and testbench

- Parametrised successor to the in-order load/store buffer. Sits between dispatch and the LS execute unit; snoops NUM_CDB result buses; talks to the ROB for store commit.
- Holds memory ops in program order and issues them from the head once operands are ready. Stores issue only after ROB commit.
- New versus the previous generation: configurable depth, widths and CDB count; count-based full with margin; committed stores survive a flush.

---
 rtl/ls_queue_pkg.sv | 27 ++
 rtl/ls_cdb_snoop.sv | 30 +++
 rtl/ls_queue.sv | 219 +++++++++++++++++++++
 tb/tb_ls_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_queue_pkg.sv
// ls_pkg: opcode encoding and helpers shared by the load/store queue and its bench.
// Loads occupy the low end of the opcode space; everything above OP_LHU is a store.
package ls_pkg;

  typedef enum logic [5:0] {
    OP_LB  = 6'd0,
    OP_LH  = 6'd1,
    OP_LW  = 6'd2,
    OP_LBU = 6'd3,
    OP_LHU = 6'd4,
    OP_SB  = 6'd5,
    OP_SH  = 6'd6,
    OP_SW  = 6'd7
  } ls_op_e;

  // Tag value meaning "operand already available".
  localparam int unsigned ZERO_ROB = 0;

  function automatic logic is_load(input logic [31:0] op);
    return op <= 32'(OP_LHU);
  endfunction

  function automatic logic is_store(input logic [31:0] op);
    return op >= 32'(OP_SB);
  endfunction

endpackage

// File: rtl/ls_cdb_snoop.sv
// ls_cdb_snoop: resolves one pending operand tag against all result buses.
// Lower bus index wins when several buses carry the same tag.
module ls_cdb_snoop
  import ls_pkg::*;
#(
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_CDB  = 2
) (
  input  logic [ROB_ID_W-1:0]         tag_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id_i,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_i,
  output logic                        hit_o,
  output logic [DATA_W-1:0]           data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int b = NUM_CDB - 1; b >= 0; b--) begin
      if (cdb_valid_i[b] && tag_i != ROB_ID_W'(ZERO_ROB) &&
          cdb_rob_id_i[b*ROB_ID_W +: ROB_ID_W] == tag_i) begin
        hit_o  = 1'b1;
        data_o = cdb_data_i[b*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue between dispatch and the LS execute unit.
// Define LS_QUEUE_PERF_EN to add saturating load/store issue and head-stall counters.
module ls_queue
  import ls_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ROB_ID_W    = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OP_W        = 6,
  parameter int unsigned NUM_CDB     = 2,
  parameter int unsigned FULL_MARGIN = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        dsp_ena_i,
  input  logic [OP_W-1:0]             dsp_op_i,
  input  logic [DATA_W-1:0]           dsp_v1_i,
  input  logic [DATA_W-1:0]           dsp_v2_i,
  input  logic [ROB_ID_W-1:0]         dsp_q1_i,
  input  logic [ROB_ID_W-1:0]         dsp_q2_i,
  input  logic [DATA_W-1:0]           dsp_imm_i,
  input  logic [ROB_ID_W-1:0]         dsp_rob_id_i,
  output logic                        full_o,
  output logic                        ex_ena_o,
  output logic [OP_W-1:0]             ex_op_o,
  output logic [DATA_W-1:0]           ex_addr_o,
  output logic [DATA_W-1:0]           ex_wdata_o,
  output logic [ROB_ID_W-1:0]         ex_rob_id_o,
  input  logic                        ex_busy_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id_i,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_i,
  input  logic                        rob_commit_i,
  input  logic [ROB_ID_W-1:0]         rob_commit_id_i,
  output logic                        store_req_o,
  output logic [ROB_ID_W-1:0]         store_req_id_o,
`ifdef LS_QUEUE_PERF_EN
  output logic [31:0]                 perf_load_o,
  output logic [31:0]                 perf_store_o,
  output logic [31:0]                 perf_stall_o,
`endif
  input  logic                        flush_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ROB_ID_W-1:0] ROB_ZERO = ROB_ID_W'(ZERO_ROB);

  logic [DEPTH-1:0]    vld_q, cmt_q;
  logic [OP_W-1:0]     op_q  [DEPTH];
  logic [DATA_W-1:0]   v1_q  [DEPTH];
  logic [DATA_W-1:0]   v2_q  [DEPTH];
  logic [DATA_W-1:0]   imm_q [DEPTH];
  logic [ROB_ID_W-1:0] q1_q  [DEPTH];
  logic [ROB_ID_W-1:0] q2_q  [DEPTH];
  logic [ROB_ID_W-1:0] rid_q [DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                lock_q;

  logic [DEPTH-1:0]  hit1, hit2;
  logic [DATA_W-1:0] wake1 [DEPTH];
  logic [DATA_W-1:0] wake2 [DEPTH];
  logic              ins_hit1, ins_hit2;
  logic [DATA_W-1:0] ins_d1, ins_d2;

  for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
    ls_cdb_snoop #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_q1 (
      .tag_i(q1_q[i]), .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i),
      .cdb_data_i(cdb_data_i), .hit_o(hit1[i]), .data_o(wake1[i])
    );
    ls_cdb_snoop #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_q2 (
      .tag_i(q2_q[i]), .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i),
      .cdb_data_i(cdb_data_i), .hit_o(hit2[i]), .data_o(wake2[i])
    );
  end

  ls_cdb_snoop #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_ins1 (
    .tag_i(dsp_q1_i), .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i),
    .cdb_data_i(cdb_data_i), .hit_o(ins_hit1), .data_o(ins_d1)
  );
  ls_cdb_snoop #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB)) u_ins2 (
    .tag_i(dsp_q2_i), .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i),
    .cdb_data_i(cdb_data_i), .hit_o(ins_hit2), .data_o(ins_d2)
  );

  logic h_vld, h_load, h_opnd_rdy, issue, req, ins;

  assign h_vld      = vld_q[head_q];
  assign h_load     = is_load(32'(op_q[head_q]));
  assign h_opnd_rdy = (q1_q[head_q] == ROB_ZERO) && (q2_q[head_q] == ROB_ZERO);
  assign issue      = !flush_i && h_vld && h_opnd_rdy && !ex_busy_i &&
                      (h_load || cmt_q[head_q]);
  assign req        = !flush_i && h_vld && h_opnd_rdy && !h_load && !cmt_q[head_q] && !lock_q;
  // A full queue silently drops the insert; the assertion below flags the dispatch bug.
  assign ins        = dsp_ena_i && (count_q != CNT_W'(DEPTH));

  // Committed stores form an unbroken run from the head; only that run survives a flush.
  logic [DEPTH-1:0] keep;
  logic [CNT_W-1:0] keep_cnt;

  always_comb begin
    logic             run;
    logic [PTR_W-1:0] idx;
    keep     = '0;
    keep_cnt = '0;
    run      = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      idx       = head_q + PTR_W'(i);
      run       = run && vld_q[idx] && cmt_q[idx] && is_store(32'(op_q[idx]));
      keep[idx] = run;
      if (run) keep_cnt = keep_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i)              count_d = keep_cnt;
    else if (ins && !issue)   count_d = count_q + CNT_W'(1);
    else if (!ins && issue)   count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q          <= '0;
      cmt_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      lock_q         <= 1'b0;
      full_o         <= 1'b0;
      ex_ena_o       <= 1'b0;
      ex_op_o        <= '0;
      ex_addr_o      <= '0;
      ex_wdata_o     <= '0;
      ex_rob_id_o    <= '0;
      store_req_o    <= 1'b0;
      store_req_id_o <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        imm_q[i] <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        rid_q[i] <= '0;
      end
    end else if (rdy) begin
      count_q <= count_d;
      full_o  <= count_d >= CNT_W'(DEPTH - FULL_MARGIN);
      if (flush_i) begin
        vld_q       <= keep;
        tail_q      <= head_q + keep_cnt[PTR_W-1:0];
        lock_q      <= 1'b0;
        ex_ena_o    <= 1'b0;
        store_req_o <= 1'b0;
      end else begin
        ex_ena_o    <= issue;
        store_req_o <= req;
        if (req) begin
          store_req_id_o <= rid_q[head_q];
          lock_q         <= 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (vld_q[i] && rob_commit_i && rid_q[i] == rob_commit_id_i) cmt_q[i] <= 1'b1;
          if (vld_q[i] && hit1[i]) begin
            q1_q[i] <= ROB_ZERO;
            v1_q[i] <= wake1[i];
          end
          if (vld_q[i] && hit2[i]) begin
            q2_q[i] <= ROB_ZERO;
            v2_q[i] <= wake2[i];
          end
        end
        if (issue) begin
          ex_op_o       <= op_q[head_q];
          ex_addr_o     <= v1_q[head_q] + imm_q[head_q];
          ex_wdata_o    <= v2_q[head_q];
          ex_rob_id_o   <= rid_q[head_q];
          vld_q[head_q] <= 1'b0;
          cmt_q[head_q] <= 1'b0;
          head_q        <= head_q + PTR_W'(1);
          lock_q        <= 1'b0;
        end
        if (ins) begin
          vld_q[tail_q] <= 1'b1;
          cmt_q[tail_q] <= 1'b0;
          op_q[tail_q]  <= dsp_op_i;
          imm_q[tail_q] <= dsp_imm_i;
          rid_q[tail_q] <= dsp_rob_id_i;
          v1_q[tail_q]  <= ins_hit1 ? ins_d1 : dsp_v1_i;
          q1_q[tail_q]  <= ins_hit1 ? ROB_ZERO : dsp_q1_i;
          v2_q[tail_q]  <= ins_hit2 ? ins_d2 : dsp_v2_i;
          q2_q[tail_q]  <= ins_hit2 ? ROB_ZERO : dsp_q2_i;
          tail_q        <= tail_q + PTR_W'(1);
        end
      end
    end
  end

  a_no_insert_when_full: assert property (@(posedge clk) disable iff (rst)
    !(rdy && !flush_i && dsp_ena_i && count_q == CNT_W'(DEPTH)));

`ifdef LS_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_o  <= '0;
      perf_store_o <= '0;
      perf_stall_o <= '0;
    end else if (rdy) begin
      if (issue && h_load && perf_load_o != '1)   perf_load_o  <= perf_load_o + 32'd1;
      if (issue && !h_load && perf_store_o != '1) perf_store_o <= perf_store_o + 32'd1;
      if (h_vld && !issue && perf_stall_o != '1)  perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: directed and randomized checks of ls_queue against a queue-level model.
module tb_ls_queue;
  import ls_pkg::*;

  localparam int DEPTH = 16;

  logic        clk, rst, rdy;
  logic        dsp_ena;
  logic [5:0]  dsp_op;
  logic [31:0] dsp_v1, dsp_v2, dsp_imm;
  logic [3:0]  dsp_q1, dsp_q2, dsp_rid;
  logic        full, ex_ena, ex_busy, rob_commit, store_req, flush;
  logic [5:0]  ex_op;
  logic [31:0] ex_addr, ex_wdata;
  logic [3:0]  ex_rid, rob_commit_id, store_req_id;
  logic [1:0]  cdb_valid;
  logic [3:0]  cdb_id [2];
  logic [31:0] cdb_dat [2];

  int total = 0;
  int bad = 0;

  ls_queue u_dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dsp_ena_i(dsp_ena), .dsp_op_i(dsp_op), .dsp_v1_i(dsp_v1), .dsp_v2_i(dsp_v2),
    .dsp_q1_i(dsp_q1), .dsp_q2_i(dsp_q2), .dsp_imm_i(dsp_imm), .dsp_rob_id_i(dsp_rid),
    .full_o(full), .ex_ena_o(ex_ena), .ex_op_o(ex_op), .ex_addr_o(ex_addr),
    .ex_wdata_o(ex_wdata), .ex_rob_id_o(ex_rid), .ex_busy_i(ex_busy),
    .cdb_valid_i(cdb_valid), .cdb_rob_id_i({cdb_id[1], cdb_id[0]}),
    .cdb_data_i({cdb_dat[1], cdb_dat[0]}), .rob_commit_i(rob_commit),
    .rob_commit_id_i(rob_commit_id), .store_req_o(store_req), .store_req_id_o(store_req_id),
    .flush_i(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-ordered list of live entries plus expected registered outputs.
  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1, v2, imm;
    logic [3:0]  q1, q2, rid;
    bit          cmt;
  } ent_t;

  ent_t        mq[$];
  bit          m_lock;
  bit          e_ena, e_req, e_full;
  logic [5:0]  e_op;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_rid, e_req_id;

  function automatic void cdb_res(input logic [3:0] tag, output bit hit, output logic [31:0] d);
    hit = 0;
    d   = '0;
    if (tag == 4'd0) return;
    for (int b = 0; b < 2; b++)
      if (!hit && cdb_valid[b] && cdb_id[b] == tag) begin
        hit = 1;
        d   = cdb_dat[b];
      end
  endfunction

  task automatic idle();
    rst = 0; rdy = 1; dsp_ena = 0; dsp_op = '0; dsp_v1 = '0; dsp_v2 = '0; dsp_imm = '0;
    dsp_q1 = '0; dsp_q2 = '0; dsp_rid = '0; ex_busy = 0; cdb_valid = '0;
    cdb_id[0] = '0; cdb_id[1] = '0; cdb_dat[0] = '0; cdb_dat[1] = '0;
    rob_commit = 0; rob_commit_id = '0; flush = 0;
  endtask

  task automatic set_ins(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [3:0] q1, input logic [3:0] q2,
                         input logic [3:0] rid);
    dsp_ena = 1; dsp_op = op; dsp_v1 = v1; dsp_v2 = v2; dsp_imm = imm;
    dsp_q1 = q1; dsp_q2 = q2; dsp_rid = rid;
  endtask

  task automatic clk_raw();
    @(posedge clk);
    #1;
  endtask

  // Advance the model by one enabled cycle with the current inputs, then clock the DUT.
  task automatic tick();
    int n, pre;
    bit h, rdy_h, st_h, iss, req;
    logic [31:0] d;
    ent_t e;
    pre = mq.size();
    if (flush) begin
      n = 0;
      while (n < mq.size() && mq[n].op > OP_LHU && mq[n].cmt) n++;
      while (mq.size() > n) void'(mq.pop_back());
      e_ena = 0; e_req = 0; m_lock = 0;
    end else begin
      iss = 0; req = 0;
      if (pre > 0) begin
        rdy_h = mq[0].q1 == 0 && mq[0].q2 == 0;
        st_h  = mq[0].op > OP_LHU;
        iss   = rdy_h && !ex_busy && (!st_h || mq[0].cmt);
        req   = rdy_h && st_h && !mq[0].cmt && !m_lock;
      end
      e_ena = iss;
      e_req = req;
      if (req) begin
        e_req_id = mq[0].rid;
        m_lock   = 1;
      end
      if (iss) begin
        e_op = mq[0].op; e_addr = mq[0].v1 + mq[0].imm; e_wdata = mq[0].v2; e_rid = mq[0].rid;
        void'(mq.pop_front());
        m_lock = 0;
      end
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (rob_commit && e.rid == rob_commit_id) e.cmt = 1;
        cdb_res(e.q1, h, d);
        if (h) begin e.q1 = 0; e.v1 = d; end
        cdb_res(e.q2, h, d);
        if (h) begin e.q2 = 0; e.v2 = d; end
        mq[i] = e;
      end
      if (dsp_ena && pre < DEPTH) begin
        e.op = dsp_op; e.imm = dsp_imm; e.rid = dsp_rid; e.cmt = 0;
        e.v1 = dsp_v1; e.q1 = dsp_q1; e.v2 = dsp_v2; e.q2 = dsp_q2;
        cdb_res(dsp_q1, h, d);
        if (h) begin e.q1 = 0; e.v1 = d; end
        cdb_res(dsp_q2, h, d);
        if (h) begin e.q2 = 0; e.v2 = d; end
        mq.push_back(e);
      end
    end
    e_full = mq.size() >= DEPTH - 1;
    clk_raw();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    clk_raw();
    clk_raw();
    rst = 0;
    mq.delete();
    m_lock = 0;
    total++; if (ex_ena !== 1'b0) begin bad++; $display("FAIL reset_ex_ena got=%b want=0", ex_ena); end
    total++; if (store_req !== 1'b0) begin bad++; $display("FAIL reset_store_req got=%b want=0", store_req); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++;
    if ({ex_op, ex_addr, ex_wdata, ex_rid, store_req_id} !== '0) begin
      bad++;
      $display("FAIL reset_data got op=%h addr=%h wdata=%h rid=%h sid=%h want all 0",
               ex_op, ex_addr, ex_wdata, ex_rid, store_req_id);
    end
  endtask

  task automatic test_load_issue();
    idle();
    set_ins(OP_LW, 32'h100, 32'h0, 32'h4, 4'd0, 4'd0, 4'd5);
    tick();
    idle();
    total++; if (ex_ena !== 1'b0) begin bad++; $display("FAIL load_early got=%b want=0", ex_ena); end
    tick();
    total++; if (ex_ena !== 1'b1) begin bad++; $display("FAIL load_ena got=%b want=1", ex_ena); end
    total++; if (ex_addr !== 32'h104) begin bad++; $display("FAIL load_addr got=%h want=104", ex_addr); end
    total++; if (ex_rid !== 4'd5) begin bad++; $display("FAIL load_rid got=%0d want=5", ex_rid); end
    total++; if (ex_op !== 6'(OP_LW)) begin bad++; $display("FAIL load_op got=%0d want=%0d", ex_op, OP_LW); end
    tick();
    total++; if (ex_ena !== 1'b0) begin bad++; $display("FAIL load_pulse got=%b want=0", ex_ena); end
  endtask

  task automatic test_store_commit();
    idle();
    set_ins(OP_SW, 32'h200, 32'h0, 32'h8, 4'd0, 4'd3, 4'd6);
    tick();
    idle();
    cdb_valid = 2'b10; cdb_id[1] = 4'd3; cdb_dat[1] = 32'hDEAD;
    tick();
    idle();
    total++; if (store_req !== 1'b0) begin bad++; $display("FAIL st_req_early got=%b want=0", store_req); end
    tick();
    total++; if (store_req !== 1'b1) begin bad++; $display("FAIL st_req got=%b want=1", store_req); end
    total++; if (store_req_id !== 4'd6) begin bad++; $display("FAIL st_req_id got=%0d want=6", store_req_id); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (store_req !== 1'b0) begin bad++; $display("FAIL st_req_repeat got=%b want=0", store_req); end
    end
    rob_commit = 1; rob_commit_id = 4'd6;
    tick();
    idle();
    total++; if (ex_ena !== 1'b0) begin bad++; $display("FAIL st_issue_early got=%b want=0", ex_ena); end
    tick();
    total++; if (ex_ena !== 1'b1) begin bad++; $display("FAIL st_ena got=%b want=1", ex_ena); end
    total++; if (ex_wdata !== 32'hDEAD) begin bad++; $display("FAIL st_wdata got=%h want=dead", ex_wdata); end
    total++; if (ex_addr !== 32'h208) begin bad++; $display("FAIL st_addr got=%h want=208", ex_addr); end
    tick();
  endtask

  task automatic test_insert_bypass();
    idle();
    cdb_valid = 2'b11;
    cdb_id[0] = 4'd7; cdb_dat[0] = 32'h3000;
    cdb_id[1] = 4'd7; cdb_dat[1] = 32'hBAD0;
    set_ins(OP_LW, 32'hFFFF, 32'h0, 32'h10, 4'd7, 4'd0, 4'd9);
    tick();
    idle();
    tick();
    total++; if (ex_ena !== 1'b1) begin bad++; $display("FAIL byp_ena got=%b want=1", ex_ena); end
    total++; if (ex_addr !== 32'h3010) begin bad++; $display("FAIL byp_addr got=%h want=3010", ex_addr); end
    tick();
  endtask

  task automatic test_fill_wrap();
    idle();
    ex_busy = 1;
    for (int k = 1; k <= 15; k++) begin
      set_ins(OP_LW, 32'(k * 16), 32'h0, 32'h0, 4'd0, 4'd0, 4'(k));
      tick();
      total++;
      if (full !== (k >= 15)) begin bad++; $display("FAIL fill_full k=%0d got=%b want=%b", k, full, k >= 15); end
    end
    ex_busy = 0;
    set_ins(OP_LW, 32'(16 * 16), 32'h0, 32'h0, 4'd0, 4'd0, 4'd0);
    tick();
    total++; if (ex_ena !== 1'b1 || ex_addr !== 32'h10) begin
      bad++; $display("FAIL fill_swap got ena=%b addr=%h want ena=1 addr=10", ex_ena, ex_addr);
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_swap_full got=%b want=1", full); end
    ex_busy = 1;
    set_ins(OP_LW, 32'(17 * 16), 32'h0, 32'h0, 4'd0, 4'd0, 4'd1);
    tick();
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_16_full got=%b want=1", full); end
    idle();
    for (int j = 0; j < 16; j++) begin
      tick();
      total++; if (ex_ena !== 1'b1 || ex_addr !== 32'((j + 2) * 16)) begin
        bad++; $display("FAIL drain j=%0d got ena=%b addr=%h want ena=1 addr=%h",
                        j, ex_ena, ex_addr, 32'((j + 2) * 16));
      end
      total++; if (full !== e_full) begin bad++; $display("FAIL drain_full j=%0d got=%b want=%b", j, full, e_full); end
    end
    tick();
    total++; if (ex_ena !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", ex_ena); end
  endtask

  task automatic test_flush();
    idle();
    ex_busy = 1;
    set_ins(OP_SW, 32'h0, 32'h55, 32'h0, 4'd0, 4'd0, 4'd2);
    tick();
    set_ins(OP_LW, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd3);
    tick();
    total++; if (store_req !== 1'b1 || store_req_id !== 4'd2) begin
      bad++; $display("FAIL fl_req got req=%b id=%0d want req=1 id=2", store_req, store_req_id);
    end
    set_ins(OP_SW, 32'h0, 32'h0, 32'h0, 4'd0, 4'd5, 4'd4);
    tick();
    idle();
    ex_busy = 1; rob_commit = 1; rob_commit_id = 4'd2;
    tick();
    idle();
    ex_busy = 1; flush = 1;
    set_ins(OP_LW, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd12);
    tick();
    idle();
    total++; if (ex_ena !== 1'b0 || store_req !== 1'b0) begin
      bad++; $display("FAIL fl_outputs got ena=%b req=%b want 0 0", ex_ena, store_req);
    end
    tick();
    total++; if (ex_ena !== 1'b1 || ex_rid !== 4'd2) begin
      bad++; $display("FAIL fl_keep got ena=%b rid=%0d want ena=1 rid=2", ex_ena, ex_rid);
    end
    tick();
    total++; if (ex_ena !== 1'b0) begin bad++; $display("FAIL fl_empty got=%b want=0", ex_ena); end
    set_ins(OP_LW, 32'h40, 32'h0, 32'h0, 4'd0, 4'd0, 4'd11);
    tick();
    idle();
    tick();
    total++; if (ex_ena !== 1'b1 || ex_rid !== 4'd11 || ex_addr !== 32'h40) begin
      bad++; $display("FAIL fl_tail got ena=%b rid=%0d addr=%h want ena=1 rid=11 addr=40",
                      ex_ena, ex_rid, ex_addr);
    end
    tick();
  endtask

  task automatic test_rdy_hold_reset();
    idle();
    set_ins(OP_LW, 32'h80, 32'h0, 32'h0, 4'd0, 4'd0, 4'd13);
    tick();
    idle();
    tick();
    rdy = 0;
    clk_raw();
    total++; if (ex_ena !== 1'b1 || ex_addr !== 32'h80) begin
      bad++; $display("FAIL hold got ena=%b addr=%h want ena=1 addr=80", ex_ena, ex_addr);
    end
    rst = 1;
    clk_raw();
    total++;
    if ({ex_ena, store_req, full, ex_op, ex_addr, ex_wdata, ex_rid, store_req_id} !== '0) begin
      bad++; $display("FAIL rst_mid got ena=%b req=%b full=%b addr=%h want all 0",
                      ex_ena, store_req, full, ex_addr);
    end
    idle();
    mq.delete();
    m_lock = 0;
    tick();
    total++; if (ex_ena !== 1'b0) begin bad++; $display("FAIL rst_after got=%b want=0", ex_ena); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      ex_busy = ($urandom_range(0, 3) == 0);
      if (mq.size() < DEPTH && $urandom_range(0, 1) == 1)
        set_ins(6'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15)),
                4'($urandom_range(1, 15)));
      for (int b = 0; b < 2; b++) begin
        cdb_valid[b] = ($urandom_range(0, 2) == 0);
        cdb_id[b]    = 4'($urandom_range(1, 15));
        cdb_dat[b]   = $urandom;
      end
      if ($urandom_range(0, 39) == 0) flush = 1;
      else if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
        rob_commit    = 1;
        rob_commit_id = mq[$urandom_range(0, mq.size() - 1)].rid;
      end
      tick();
      total++; if (ex_ena !== e_ena) begin bad++; $display("FAIL rnd_ena c=%0d got=%b want=%b", c, ex_ena, e_ena); end
      total++; if (store_req !== e_req) begin bad++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, store_req, e_req); end
      total++; if (full !== e_full) begin bad++; $display("FAIL rnd_full c=%0d got=%b want=%b", c, full, e_full); end
      if (e_ena) begin
        total++;
        if (ex_op !== e_op || ex_addr !== e_addr || ex_wdata !== e_wdata || ex_rid !== e_rid) begin
          bad++; $display("FAIL rnd_issue c=%0d got op=%0d addr=%h wd=%h rid=%0d want op=%0d addr=%h wd=%h rid=%0d",
                          c, ex_op, ex_addr, ex_wdata, ex_rid, e_op, e_addr, e_wdata, e_rid);
        end
      end
      if (e_req) begin
        total++;
        if (store_req_id !== e_req_id) begin
          bad++; $display("FAIL rnd_req_id c=%0d got=%0d want=%0d", c, store_req_id, e_req_id);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_issue();
    test_store_commit();
    test_insert_bypass();
    test_fill_wrap();
    test_flush();
    test_rdy_hold_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
